rv32i_lsu: RTL
==============

// Module: rv32i_lsu
// PURPOSE
//  Load/store unit for the MEM stage; sits between rv32i_exTop and rv32i_wbTop.
//  - Drives the data port of the dual-port RAM and a small memory-mapped IO register bank.
//  - Aligns and sign-extends load data.
//  - Forwards results to decode.
//  - Flags misaligned accesses. One instruction per cycle, no stalls generated internally.
// PARAMETERS
//  IO_BASE   32'h8000_0000  addresses >= IO_BASE hit the IO bank, below hit RAM
//  IO_REGS   4              number of 32-bit IO registers (word-indexed from IO_BASE)
// PORTS
//  clk            in   1    clock
//  reset_n        in   1    reset, asynchronous, active-low
//  pc_in          in   32   PC from EX
//  iw_in          in   32   instruction word from EX
//  alu_in         in   32   ALU result / effective address from EX
//  rs2_data_in    in   32   store data from EX
//  wb_en_in       in   1    writeback enable from EX
//  wb_reg_in      in   5    destination register from EX
//  d_addr         out  30   RAM word address (alu_in[31:2]), combinational
//  d_wdata        out  32   RAM write data, byte-lane replicated, combinational
//  d_be           out  4    RAM byte enables, combinational
//  d_we           out  1    RAM write strobe, combinational
//  d_rdata        in   32   RAM read data, valid one cycle after d_addr
//  io_out         out  32*IO_REGS  IO register contents (LEDs/HEX etc.)
//  pc_out         out  32   registered PC to WB
//  iw_out         out  32   registered IW to WB
//  wb_en_out      out  1    registered writeback enable to WB
//  wb_reg_out     out  5    registered destination register to WB
//  wb_data        out  32   writeback value to WB: aligned load data or registered ALU value
//  df_mem_enable  out  1    forward valid (= wb_en_out for non-loads, 0 for loads)
//  df_mem_reg     out  5    forward register (= wb_reg_out)
//  df_mem_data    out  32   forward data (= registered ALU value)
//  df_mem_is_load out  1    registered: stage holds a load; ID must stall on rd match
//  misalign_err   out  1    sticky misaligned-access flag
// BEHAVIOUR
//  - Reset (reset_n low, async):
//    - All registered outputs, io_out, misalign_err and internal pending-load state are 0.
//    - d_we=0 and d_be=0 are forced while in reset.
//  - Decode: LOAD = opcode 7'b0000011; STORE = opcode 7'b0100011.
//    - funct3 = iw_in[14:12]: 000 B, 001 H, 010 W, 100 BU, 101 HU. Other funct3 values are treated as no-op.
//  - Alignment: H requires addr[0]=0; W requires addr[1:0]=0.
//    - A misaligned access sets misalign_err (sticky until reset), suppresses d_we/IO write, and clears wb_en_out.
//  - STORE to RAM (addr < IO_BASE, aligned), same cycle as input:
//    - d_we=1.
//    - d_be: B = 4'b0001 << addr[1:0]; H = 4'b0011 << addr[1:0]; W = 4'b1111.
//    - d_wdata: B = {4{rs2[7:0]}}; H = {2{rs2[15:0]}}; W = rs2.
//  - STORE to IO:
//    - Only W stores are honoured. Index = (addr - IO_BASE) >> 2; index >= IO_REGS is ignored.
//    - Register updates at the clock edge. RAM d_we=0.
//  - LOAD (latency 1):
//    - Address is presented at cycle N. At edge N the unit captures size, sign, addr[1:0] and an is_io flag.
//      For IO, the selected register value is captured at edge N (reads the value before any same-edge store).
//    - In cycle N+1, wb_data = extract(source >> 8*offset) with sign/zero extension, where source is d_rdata or the captured IO value.
//    - A non-existent IO index reads 0.
//  - Non-load:
//    - wb_data = alu_in registered at edge N.
//    - df_mem_* presents the same value in cycle N+1.
//  - Back-to-back:
//    - Store at N followed by load of the same address at N+1 must return the stored data (RAM write completes at edge N).
//    - An IO store at N followed by an IO load at N+1 returns the new value.
//  - Reset asserted mid-load: the pending load is discarded; wb_data=0 and wb_en_out=0 until new input.
//  - d_addr is always alu_in[31:2] (harmless reads for non-loads).
// STRUCTURE
//  - rv32i_pkg:
//    - Opcode constants (OP_LOAD, OP_STORE).
//    - Funct3 constants.
//    - typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_t.
//    - Function is_aligned().
//  - Sub-module rv32i_load_align: combinational (data, offset, size, unsigned) -> 32-bit extended value.
//  - Top contains stage registers, the IO bank and byte-lane logic.
// TESTING
//  1. Store SW x=32'hDEADBEEF @0x100 -> d_we=1, d_be=4'hF, d_addr=30'h40; LW @0x100 next cycle -> wb_data=32'hDEADBEEF.
//  2. SB 8'h80 @0x103, then LB @0x103 -> wb_data=32'hFFFFFF80; LBU -> 32'h00000080; d_be on store = 4'b1000.
//  3. SH 16'h8001 @0x102, LH -> 32'hFFFF8001; LHU -> 32'h00008001; SH @0x101 -> d_we=0, misalign_err=1, stays 1.
//  4. SW 32'h5 @IO_BASE+4 -> io_out word1=5, d_we=0; LW @IO_BASE+4 next cycle -> wb_data=5; LW @IO_BASE+16 -> 0.
//  5. ADD result 32'h1234 with wb_en=1, rd=7 -> next cycle df_mem_enable=1, df_mem_reg=7, df_mem_data=32'h1234, df_mem_is_load=0; LW -> df_mem_is_load=1.
//  6. Issue LW, assert reset_n=0 mid-cycle -> all outputs 0 immediately; after release with no-op input, wb_en_out=0.

Source files
------------

// File: rtl/rv32i_pkg.sv
// Shared decode constants, access-size type and alignment rule for the MEM stage.
package rv32i_pkg;
  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W} mem_size_t;

  function automatic logic is_aligned(input mem_size_t sz, input logic [1:0] off);
    case (sz)
      SZ_H:    return ~off[0];
      SZ_W:    return off == 2'b00;
      default: return 1'b1;
    endcase
  endfunction
endpackage

// File: rtl/rv32i_load_align.sv
// Load data aligner: shifts the addressed lane down and sign/zero-extends it.
// Purely combinational, no latency and no flow control.
module rv32i_load_align
  import rv32i_pkg::*;
(
  input  logic [31:0] data,
  input  logic [1:0]  offset,
  input  mem_size_t   size,
  input  logic        is_unsigned,
  output logic [31:0] result
);
  logic [31:0] shifted;

  always_comb begin
    shifted = data >> {offset, 3'b000};
    case (size)
      SZ_B:    result = is_unsigned ? {24'h0, shifted[7:0]} : {{24{shifted[7]}}, shifted[7:0]};
      SZ_H:    result = is_unsigned ? {16'h0, shifted[15:0]} : {{16{shifted[15]}}, shifted[15:0]};
      default: result = shifted;
    endcase
  end
endmodule

// File: rtl/rv32i_lsu.sv
// MEM stage: RAM data port, IO register bank, load alignment and forwarding to decode.
// Store/address outputs are combinational, load data returns one cycle later; never stalls.
module rv32i_lsu
  import rv32i_pkg::*;
#(
  parameter logic [31:0] IO_BASE = 32'h8000_0000,
  parameter int          IO_REGS = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [31:0]            pc_in,
  input  logic [31:0]            iw_in,
  input  logic [31:0]            alu_in,
  input  logic [31:0]            rs2_data_in,
  input  logic                   wb_en_in,
  input  logic [4:0]             wb_reg_in,
  output logic [29:0]            d_addr,
  output logic [31:0]            d_wdata,
  output logic [3:0]             d_be,
  output logic                   d_we,
  input  logic [31:0]            d_rdata,
  output logic [32*IO_REGS-1:0]  io_out,
  output logic [31:0]            pc_out,
  output logic [31:0]            iw_out,
  output logic                   wb_en_out,
  output logic [4:0]             wb_reg_out,
  output logic [31:0]            wb_data,
  output logic                   df_mem_enable,
  output logic [4:0]             df_mem_reg,
  output logic [31:0]            df_mem_data,
  output logic                   df_mem_is_load,
  output logic                   misalign_err
);
  logic [6:0]  opcode;
  logic [2:0]  funct3;
  mem_size_t   size;
  logic        is_unsigned, funct3_ok;
  logic        is_load, is_store, misalign, is_io, ram_we, io_we;
  logic [29:0] io_idx;
  logic [3:0]  be;
  logic [31:0] io_rdata;
  logic [IO_REGS-1:0][31:0] io_regs;

  logic [31:0] alu_q, io_val_q, load_src, load_data;
  logic        load_q, load_io_q, load_uns_q, err_q;
  mem_size_t   load_size_q;
  logic [1:0]  load_off_q;

  assign opcode = iw_in[6:0];
  assign funct3 = iw_in[14:12];

  always_comb begin
    size        = SZ_W;
    is_unsigned = 1'b0;
    funct3_ok   = 1'b1;
    case (funct3)
      F3_B:    size = SZ_B;
      F3_H:    size = SZ_H;
      F3_W:    size = SZ_W;
      F3_BU:   begin size = SZ_B; is_unsigned = 1'b1; end
      F3_HU:   begin size = SZ_H; is_unsigned = 1'b1; end
      default: funct3_ok = 1'b0;
    endcase
  end

  assign is_load  = funct3_ok && (opcode == OP_LOAD);
  assign is_store = funct3_ok && (opcode == OP_STORE);
  assign misalign = (is_load || is_store) && !is_aligned(size, alu_in[1:0]);
  assign is_io    = alu_in >= IO_BASE;
  assign io_idx   = alu_in[31:2] - IO_BASE[31:2];
  assign ram_we   = is_store && !misalign && !is_io;
  assign io_we    = is_store && !misalign && is_io && (size == SZ_W);

  always_comb begin
    case (size)
      SZ_B:    begin be = 4'b0001 << alu_in[1:0]; d_wdata = {4{rs2_data_in[7:0]}}; end
      SZ_H:    begin be = 4'b0011 << alu_in[1:0]; d_wdata = {2{rs2_data_in[15:0]}}; end
      default: begin be = 4'b1111;                d_wdata = rs2_data_in; end
    endcase
  end

  // Strobes are gated by reset so the RAM sees no write while the core is held.
  assign d_addr = alu_in[31:2];
  assign d_we   = reset_n & ram_we;
  assign d_be   = (reset_n && ram_we) ? be : 4'b0000;

  // Out-of-range indices match nothing and read back as zero.
  always_comb begin
    io_rdata = '0;
    for (int i = 0; i < IO_REGS; i++)
      if (io_idx == 30'(i)) io_rdata = io_regs[i];
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pc_out      <= '0;
      iw_out      <= '0;
      wb_en_out   <= 1'b0;
      wb_reg_out  <= '0;
      alu_q       <= '0;
      load_q      <= 1'b0;
      load_io_q   <= 1'b0;
      load_uns_q  <= 1'b0;
      load_size_q <= SZ_B;
      load_off_q  <= '0;
      io_val_q    <= '0;
      err_q       <= 1'b0;
      io_regs     <= '0;
    end else begin
      pc_out      <= pc_in;
      iw_out      <= iw_in;
      wb_en_out   <= wb_en_in && !misalign;
      wb_reg_out  <= wb_reg_in;
      alu_q       <= alu_in;
      load_q      <= is_load && !misalign;
      load_io_q   <= is_io;
      load_uns_q  <= is_unsigned;
      load_size_q <= size;
      load_off_q  <= alu_in[1:0];
      io_val_q    <= io_rdata;
      if (misalign) err_q <= 1'b1;
      for (int i = 0; i < IO_REGS; i++)
        if (io_we && io_idx == 30'(i)) io_regs[i] <= rs2_data_in;
    end
  end

  assign load_src = load_io_q ? io_val_q : d_rdata;

  rv32i_load_align u_align (
    .data        (load_src),
    .offset      (load_off_q),
    .size        (load_size_q),
    .is_unsigned (load_uns_q),
    .result      (load_data)
  );

  assign io_out         = io_regs;
  assign wb_data        = load_q ? load_data : alu_q;
  assign df_mem_enable  = wb_en_out && !load_q;
  assign df_mem_reg     = wb_reg_out;
  assign df_mem_data    = alu_q;
  assign df_mem_is_load = load_q;
  assign misalign_err   = err_q;
endmodule
